// File: rtl/lsu_mem_responder_pkg.sv
// Shared types for the LSU memory responder: FSM states, byte-enable
// type, lane count and the byte-lane merge helper.
package lsu_pkg;

    localparam int LANES = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } lsu_resp_state_e;

    typedef logic [3:0] byte_en_t;

    // Lanes with be[k]=1 take new_w, the rest keep old_w.
    function automatic logic [31:0] lane_merge(
        input logic [31:0] old_w,
        input logic [31:0] new_w,
        input byte_en_t    be
    );
        logic [31:0] res;
        res = old_w;
        for (int k = 0; k < LANES; k++) begin
            if (be[k]) res[8*k +: 8] = new_w[8*k +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/lsu_mem_responder_if.sv
// LSU read/write bus between the execute stage (master) and the responder
// (slave). lsu_err only exists when LSU_RESP_ERR_EN is defined.
interface lsu_mem_responder_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    import lsu_pkg::*;

    logic          lsu_read;
    logic [AW-1:0] r_lsu_addr;
    logic [DW-1:0] r_lsu_data;
    logic          lsu_ack;
    logic          lsu_write;
    logic [AW-1:0] w_lsu_addr;
    byte_en_t      w_lsu_byte_en;
    logic [DW-1:0] w_lsu_data;
`ifdef LSU_RESP_ERR_EN
    logic          lsu_err;
`endif

    modport master (
`ifdef LSU_RESP_ERR_EN
        input  lsu_err,
`endif
        output lsu_read, r_lsu_addr,
        input  r_lsu_data, lsu_ack,
        output lsu_write, w_lsu_addr, w_lsu_byte_en, w_lsu_data
    );

    modport slave (
`ifdef LSU_RESP_ERR_EN
        output lsu_err,
`endif
        input  lsu_read, r_lsu_addr,
        output r_lsu_data, lsu_ack,
        input  lsu_write, w_lsu_addr, w_lsu_byte_en, w_lsu_data
    );

endinterface

// File: rtl/lsu_mem_responder_ram_bank.sv
// lsu_ram_bank: DEPTH x 32 word RAM, one byte-lane-enabled write port and
// one asynchronous read port. Ports: clk, we, be, waddr, wdata, raddr, rdata.
module lsu_ram_bank
    import lsu_pkg::*;
#(
    parameter int DEPTH     = 1024,
    parameter     INIT_FILE = "",
    localparam int IW       = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  byte_en_t      be,
    input  logic [IW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [IW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < LANES; k++) begin
                if (be[k]) mem[waddr][8*k +: 8] <= wdata[8*k +: 8];
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/lsu_mem_responder.sv
// LSU memory responder: fixed-latency word loads with a one-cycle ack and
// single-cycle byte-enabled stores. Ports: i_clk, i_rst (sync, active-low),
// i_clk_en (freeze), lsu (slave side of lsu_mem_responder_if).
// Optional macro LSU_RESP_ERR_EN adds out-of-range detection on lsu_err.
module lsu_mem_responder
    import lsu_pkg::*;
#(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int DEPTH    = 1024,
    parameter int READ_LAT = 1,
    parameter     INIT_FILE = ""
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_clk_en,
    lsu_mem_responder_if.slave lsu
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = 4;

    lsu_resp_state_e state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [DW-1:0]   data_q;
    logic            ack_q;
    logic            cap;

    logic [IW-1:0]   r_idx, w_idx, rd_idx;
    logic [31:0]     ram_rdata, cap_word;
    logic            ram_we;

    assign r_idx = lsu.r_lsu_addr[IW+1:2];
    assign w_idx = lsu.w_lsu_addr[IW+1:2];

`ifdef LSU_RESP_ERR_EN
    logic r_oor, w_oor, oor_q, oor_d, rd_oor, err_q;
    assign r_oor  = lsu.r_lsu_addr[AW-1:2] >= (AW-2)'(DEPTH);
    assign w_oor  = lsu.w_lsu_addr[AW-1:2] >= (AW-2)'(DEPTH);
    assign rd_oor = (state_q == IDLE) ? r_oor : oor_q;
    assign ram_we = i_clk_en && lsu.lsu_write && !w_oor;
`else
    assign ram_we = i_clk_en && lsu.lsu_write;
`endif

    // With READ_LAT==1 capture happens on the accept edge, before the
    // index register is loaded, so IDLE reads through the live address.
    assign rd_idx = (state_q == IDLE) ? r_idx : idx_q;

    lsu_ram_bank #(
        .DEPTH    (DEPTH),
        .INIT_FILE(INIT_FILE)
    ) u_ram (
        .clk  (i_clk),
        .we   (ram_we),
        .be   (lsu.w_lsu_byte_en),
        .waddr(w_idx),
        .wdata(lsu.w_lsu_data),
        .raddr(rd_idx),
        .rdata(ram_rdata)
    );

    // Write-first: a store landing on the captured word in the same edge
    // is merged into the load data.
    always_comb begin
        cap_word = ram_rdata;
        if (ram_we && (w_idx == rd_idx))
            cap_word = lane_merge(ram_rdata, lsu.w_lsu_data, lsu.w_lsu_byte_en);
`ifdef LSU_RESP_ERR_EN
        if (rd_oor) cap_word = '0;
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        cap     = 1'b0;
`ifdef LSU_RESP_ERR_EN
        oor_d   = oor_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (lsu.lsu_read) begin
                    idx_d = r_idx;
                    cnt_d = CW'(READ_LAT - 1);
`ifdef LSU_RESP_ERR_EN
                    oor_d = r_oor;
`endif
                    if (READ_LAT == 1) begin
                        state_d = ACK;
                        cap     = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = ACK;
                    cap     = 1'b1;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            ack_q   <= 1'b0;
`ifdef LSU_RESP_ERR_EN
            oor_q   <= 1'b0;
            err_q   <= 1'b0;
`endif
        end else if (i_clk_en) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            ack_q   <= (state_q == ACK);
            if (cap) data_q <= cap_word;
`ifdef LSU_RESP_ERR_EN
            oor_q   <= oor_d;
            err_q   <= ((state_q == ACK) && oor_q) ||
                       (lsu.lsu_write && w_oor);
`endif
        end
    end

    assign lsu.r_lsu_data = data_q;
    assign lsu.lsu_ack    = ack_q;
`ifdef LSU_RESP_ERR_EN
    assign lsu.lsu_err    = err_q;
`endif

endmodule

// File: tb/tb_lsu_mem_responder.sv
// Randomized self-checking bench for lsu_mem_responder against a
// word-array reference model (DEPTH=16, READ_LAT=3).
module tb_lsu_mem_responder;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int LAT   = 3;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic clk_en = 1'b1;

    always #5 clk = ~clk;

    lsu_mem_responder_if #(.AW(AW), .DW(DW)) bus ();

    lsu_mem_responder #(
        .AW       (AW),
        .DW       (DW),
        .DEPTH    (DEPTH),
        .READ_LAT (LAT),
        .INIT_FILE("")
    ) dut (
        .i_clk   (clk),
        .i_rst   (rst_n),
        .i_clk_en(clk_en),
        .lsu     (bus.slave)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem [DEPTH];
    logic        err_exp = 1'b0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit oor(input logic [31:0] a);
`ifdef LSU_RESP_ERR_EN
        return a[31:2] >= DEPTH;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'(a[31:2]) % DEPTH;
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        if (oor(a)) return 32'h0;
        return mem[widx(a)];
    endfunction

    task automatic model_wr(input logic [31:0] a, input logic [3:0] be,
                            input logic [31:0] d);
        if (!oor(a)) begin
            for (int k = 0; k < 4; k++)
                if (be[k]) mem[widx(a)][8*k +: 8] = d[8*k +: 8];
        end
    endtask

    task automatic do_store(input logic [31:0] a, input logic [3:0] be,
                            input logic [31:0] d);
        bus.lsu_write     = 1'b1;
        bus.w_lsu_addr    = a;
        bus.w_lsu_byte_en = be;
        bus.w_lsu_data    = d;
        @(posedge clk);
        model_wr(a, be, d);
        err_exp = oor(a);
        @(negedge clk);
        bus.lsu_write = 1'b0;
        check("st_ack", {31'b0, bus.lsu_ack}, 32'h0);
`ifdef LSU_RESP_ERR_EN
        check("st_err", {31'b0, bus.lsu_err}, {31'b0, err_exp});
`endif
    endtask

    // Load with an optional store at edge st_j (0 = accept edge) and an
    // optional clock-enable gap of g_n edges starting at edge g_j.
    task automatic do_load(input string tag, input logic [31:0] a,
                           input int st_j, input logic [31:0] st_a,
                           input logic [3:0] st_be, input logic [31:0] st_d,
                           input int g_j, input int g_n);
        int          eff;
        bit          done;
        bit          s_err;
        bit          ld_oor;
        logic [31:0] exp_d;
        eff    = 0;
        done   = 0;
        ld_oor = oor(a);
        exp_d  = 32'h0;
        bus.lsu_read   = 1'b1;
        bus.r_lsu_addr = a;
        for (int j = 0; j < 40 && !done; j++) begin
            clk_en            = !(j >= g_j && j < g_j + g_n);
            bus.lsu_write     = (j == st_j);
            bus.w_lsu_addr    = st_a;
            bus.w_lsu_byte_en = st_be;
            bus.w_lsu_data    = st_d;
            @(posedge clk);
            if (clk_en) begin
                s_err = 0;
                if (bus.lsu_write) begin
                    model_wr(st_a, st_be, st_d);
                    s_err = oor(st_a);
                end
                if (eff == LAT - 1) exp_d = model_rd(a);
                eff++;
                err_exp = ((eff == LAT + 1) && ld_oor) || s_err;
            end
            @(negedge clk);
            bus.lsu_write = 1'b0;
            clk_en        = 1'b1;
`ifdef LSU_RESP_ERR_EN
            check({tag, "_err"}, {31'b0, bus.lsu_err}, {31'b0, err_exp});
`endif
            if (bus.lsu_ack) begin
                done = 1;
                bus.lsu_read = 1'b0;
                check({tag, "_lat"}, eff, LAT + 1);
                check({tag, "_data"}, bus.r_lsu_data, exp_d);
            end
        end
        if (!done) begin
            bus.lsu_read = 1'b0;
            check({tag, "_timeout"}, {31'b0, bus.lsu_ack}, 32'h1);
        end
    endtask

    initial begin
        logic [31:0] ra, sa, sd;
        logic [3:0]  sb;
        int          sj, gn;

        bus.lsu_read      = 1'b0;
        bus.r_lsu_addr    = '0;
        bus.lsu_write     = 1'b0;
        bus.w_lsu_addr    = '0;
        bus.w_lsu_byte_en = '0;
        bus.w_lsu_data    = '0;

        repeat (2) @(negedge clk);
        check("rst_ack", {31'b0, bus.lsu_ack}, 32'h0);
        check("rst_data", bus.r_lsu_data, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < DEPTH; i++) do_store(32'(i * 4), 4'hF, $urandom);

        do_load("pre", 32'h0C, -1, 0, 0, 0, 0, 0);

        // Reset held 3 cycles with a load requested.
        rst_n          = 1'b0;
        bus.lsu_read   = 1'b1;
        bus.r_lsu_addr = 32'h08;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check("rsth_ack", {31'b0, bus.lsu_ack}, 32'h0);
            check("rsth_data", bus.r_lsu_data, 32'h0);
        end
        err_exp = 1'b0;
        rst_n   = 1'b1;
        do_load("rst_rel", 32'h08, -1, 0, 0, 0, 0, 0);

        do_store(32'h20, 4'hF, 32'hDEADBEEF);
        do_load("full", 32'h20, -1, 0, 0, 0, 0, 0);
        do_store(32'h20, 4'b0101, 32'h11223344);
        do_load("merge", 32'h22, -1, 0, 0, 0, 0, 0);
        check("merge_model", model_rd(32'h20), 32'hDE22BE44);

        do_load("wfirst", 32'h30, 1, 32'h30, 4'hF, 32'hCAFEF00D, 0, 0);
        do_load("capedge", 32'h34, LAT - 1, 32'h34, 4'b1010,
                32'hA5A5A5A5, 0, 0);
        do_load("same_acc", 32'h28, 0, 32'h28, 4'b0011, 32'h0000BEEF, 0, 0);
        do_load("nobe", 32'h2C, 1, 32'h2C, 4'h0, 32'hFFFFFFFF, 0, 0);

        do_load("gate", 32'h24, 2, 32'h24, 4'hF, 32'h12345678, 1, 5);
        do_load("gate_chk", 32'h24, -1, 0, 0, 0, 0, 0);

        do_load("hi_ld", 32'h40, -1, 0, 0, 0, 0, 0);
        do_store(32'h44, 4'hF, 32'h55AA55AA);
        do_load("hi_chk", 32'h04, -1, 0, 0, 0, 0, 0);

        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                sa = {$urandom_range(0, 31), 2'($urandom)};
                do_store(sa, 4'($urandom), $urandom);
            end else begin
                ra = {$urandom_range(0, 31), 2'($urandom)};
                sj = $urandom_range(0, 1) ? int'($urandom_range(0, LAT + 1)) : -1;
                sa = $urandom_range(0, 1) ? ra : {$urandom_range(0, 31), 2'b00};
                sb = 4'($urandom);
                sd = $urandom;
                gn = $urandom_range(0, 3) == 0 ? int'($urandom_range(1, 4)) : 0;
                do_load("rnd", ra, sj, sa, sb, sd, 1, gn);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
